// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: line constants, arbiter state encoding and
// default sizing for the byte-source arbiter in front of the UART TX top.
package uart_tx_arbiter_pkg;

  localparam logic UartStartBit = 1'b0;
  localparam logic UartStopBit  = 1'b1;
  localparam int   UartStopBits = 1;

  localparam int DefNrOfRequesters = 4;
  localparam int DefNrOfDataBits   = 8;
  localparam int DefStartTimeout   = 16;

  typedef enum logic [1:0] {
    ArbIdle     = 2'd0,
    ArbLaunch   = 2'd1,
    ArbWaitBusy = 2'd2,
    ArbWaitDone = 2'd3
  } arb_state_e;

  // Index width for a one-of-n selection; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_select.sv
// Round-robin picker: first requester found scanning upward from the
// position after the last owner, wrapping at NrOfRequesters.
module rr_priority_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NrOfRequesters = DefNrOfRequesters,
  localparam int IdxW = idx_width(NrOfRequesters)
) (
  input  logic [NrOfRequesters-1:0] request,
  input  logic [IdxW-1:0]           lastOwner,
  output logic [NrOfRequesters-1:0] pick,
  output logic [IdxW-1:0]           index
);

  // Scan the N candidates after lastOwner; the first hit wins.
  always_comb begin
    pick  = '0;
    index = '0;
    for (int k = 1; k <= NrOfRequesters; k++) begin
      int  cand;
      cand = int'(lastOwner) + k;
      if (cand >= NrOfRequesters) cand = cand - NrOfRequesters;
      if (pick == '0 && request[cand]) begin
        pick[cand] = 1'b1;
        index      = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbiter sharing one UART transmitter between several byte sources.
// Drives the existing TX top through txStart/txData/txDone.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ArbIdle     | no owner; arbitrate once a request is up and TX idle
//   ArbLaunch   | byte latched, issue the one-cycle txStart next
//   ArbWaitBusy | waiting for txDone to fall, bounded by StartTimeout
//   ArbWaitDone | byte on the line; on txDone high chain or release
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NrOfRequesters = DefNrOfRequesters,
  parameter int NrOfDataBits   = DefNrOfDataBits,
  parameter int StartTimeout   = DefStartTimeout
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NrOfRequesters-1:0]              request,
  input  logic [NrOfRequesters*NrOfDataBits-1:0] dataIn,
  input  logic [NrOfRequesters-1:0]              lock,
  output logic [NrOfRequesters-1:0]              grant,
  output logic [NrOfRequesters-1:0]              accepted,
  output logic                                   txStart,
  output logic [NrOfDataBits-1:0]                txData,
  input  logic                                   txDone,
  output logic                                   timeoutError
);

  localparam int IdxW = idx_width(NrOfRequesters);
  localparam int CntW = $clog2(StartTimeout + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(StartTimeout - 1);

  arb_state_e                state_q, state_d;
  logic [NrOfRequesters-1:0] grant_q, grant_d;
  logic [NrOfRequesters-1:0] accepted_q, accepted_d;
  logic [IdxW-1:0]           owner_q, owner_d;
  logic [IdxW-1:0]           last_owner_q, last_owner_d;
  logic [NrOfDataBits-1:0]   tx_data_q, tx_data_d;
  logic                      tx_start_q, tx_start_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      timeout_err_q, timeout_err_d;

  logic [NrOfRequesters-1:0] rr_pick;
  logic [IdxW-1:0]           rr_index;

  rr_priority_select #(
    .NrOfRequesters(NrOfRequesters)
  ) u_rr (
    .request  (request),
    .lastOwner(last_owner_q),
    .pick     (rr_pick),
    .index    (rr_index)
  );

  // Next-state and registered-output decode; every target defaults to hold
  // or to its idle pulse value.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    accepted_d    = '0;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ArbIdle: begin
        if (|request && txDone) begin
          grant_d    = rr_pick;
          owner_d    = rr_index;
          tx_data_d  = dataIn[int'(rr_index)*NrOfDataBits +: NrOfDataBits];
          accepted_d = rr_pick;
          state_d    = ArbLaunch;
        end
      end
      ArbLaunch: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = ArbWaitBusy;
      end
      ArbWaitBusy: begin
        if (!txDone) begin
          state_d = ArbWaitDone;
        end else if (cnt_q == CntLast) begin
          // Transmitter never acknowledged; flag it and fall through so the
          // arbiter keeps serving other sources.
          timeout_err_d = 1'b1;
          state_d       = ArbWaitDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ArbWaitDone: begin
        if (txDone) begin
          if (lock[owner_q] && request[owner_q]) begin
            tx_data_d  = dataIn[int'(owner_q)*NrOfDataBits +: NrOfDataBits];
            accepted_d = grant_q;
            state_d    = ArbLaunch;
          end else begin
            grant_d      = '0;
            last_owner_d = owner_q;
            state_d      = ArbIdle;
          end
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // State and output registers; reset abandons any byte in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ArbIdle;
      grant_q       <= '0;
      accepted_q    <= '0;
      owner_q       <= '0;
      last_owner_q  <= IdxW'(NrOfRequesters - 1);
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      accepted_q    <= accepted_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant        = grant_q;
  assign accepted     = accepted_q;
  assign txStart      = tx_start_q;
  assign txData       = tx_data_q;
  assign timeoutError = timeout_err_q;

endmodule
